rgb_fade_ctrl: RTL
==================

Name: rgb_fade_ctrl

Overview:
- Upstream stage of the RGB PWM LED driver: converts a 3-bit colour code into the three 8-bit duty values (R/G/B time-in) the PWM stage consumes.
- Ramps each channel linearly toward the palette target at a programmable rate (smooth fade) and applies a global brightness scale.
- Reports fade progress with busy/done flags.

Parameters:
- PRESCALE, 256: clk cycles per fade tick (256 = one PWM period); legal range ≥2.
- STEP, 8: maximum per-tick change of each channel level; legal range 1..255.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous reset, active-high
- color_in  in  3  requested colour code (0 red, 1 orange, 2 yellow, 3 green, 4 blue, 5 indigo, 6 purple, 7 off)
- color_valid  in  1  accept color_in this cycle (always accepted, no ready)
- brightness  in  8  global scale; 8'hFF = pass-through
- R_duty  out  8  red duty to PWM stage
- G_duty  out  8  green duty to PWM stage
- B_duty  out  8  blue duty to PWM stage
- busy  out  1  high while state = FADE
- done  out  1  one-cycle pulse when a fade completes

Behaviour:
- Reset (async): target = off (0,0,0); levels = 0; prescaler = 0; state = IDLE; R/G/B_duty = 0; busy = 0; done = 0.
- Palette (R,G,B):
  - 0 (255,0,0), 1 (255,128,0), 2 (255,255,0), 3 (0,255,0)
  - 4 (0,0,255), 5 (75,0,130), 6 (143,0,255), 7 (0,0,0)
- Prescaler:
  - Free-running 0..PRESCALE-1, wraps to 0.
  - tick = 1 in the cycle the count equals PRESCALE-1.
  - Never reset by color_valid.
- Accept: on color_valid, the target registers load the palette entry at the next edge and state → FADE. This is also legal mid-fade (retarget); the fade continues from the current levels with no jump.
- State machine:
  - IDLE: levels frozen. color_valid → FADE.
  - FADE: on tick, each channel steps:
    - if level < tgt: level = tgt when (tgt − level) ≤ STEP, else level + STEP.
    - if level > tgt: level = tgt when (level − tgt) ≤ STEP, else level − STEP.
    - Arithmetic in 9 bits; no wrap.
  - FADE completion: on a tick where all three levels already equal the target (before stepping) → done = 1 next cycle, state → IDLE.
  - A same-colour request therefore completes on the next tick.
- Simultaneous color_valid and tick: the step uses the OLD target. The new target loads on the same edge, and state stays/becomes FADE. A completion check on that tick is suppressed (no done).
- Scaling:
  - duty = (level × brightness) >> 8, a 16-bit product.
  - brightness = 8'hFF bypasses scaling (duty = level).
  - brightness = 0 gives duty 0.
- Timing:
  - Duties are registered, one cycle after the level or brightness change.
  - busy is registered and mirrors state.
  - brightness may change at any time; it takes effect next cycle without affecting the fade.
- Reset mid-fade: all outputs return to reset values immediately (async).

Decomposition:
- Shared package (rgb_pkg):
  - colour code constants 0..7, common with the PWM stage's colour enum;
  - palette R/G/B constant table;
  - state encoding (IDLE, FADE).
- Sub-module rgb_ramp_channel:
  - one 8-bit level register with saturating step toward the target, plus an at_target flag;
  - instanced ×3.
- Prescaler, FSM and scaling stay in the top module.

Test Plan (PRESCALE=4, STEP=64 unless noted):
- Reset release, no requests → duties 0, busy 0, done never pulses over 100 cycles.
- color 0 from off → R levels 64, 128, 192, 255 on ticks 1–4; G = B = 0. Completion check on tick 5, done pulse one cycle later; busy falls with done.
- color 0 then color 3 after done → R 191, 127, 63, 0 and G 64, 128, 192, 255 over 4 ticks; done after tick 5.
- Retarget mid-fade: red → green, then color 4 after tick 2 (R=127, G=128) → no done yet. Ticks 3–4 step to R=63,0 / G=64,0 with B=64,128; continue to B=255, then single done.
- color_valid coincident with tick → step uses old target, new target loaded, no spurious done.
- brightness 128 at red complete → R_duty = 127 next cycle. brightness 0 → all duties 0. brightness 255 → R_duty 255.
- Assert rst during FADE (R=128) → duties/busy 0 immediately. After release, the first request fades from 0.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB LED path: colour codes, palette table,
// fade state encoding and the brightness scaling helper.
package rgb_pkg;

  typedef enum logic [2:0] {
    COLOR_RED    = 3'd0,
    COLOR_ORANGE = 3'd1,
    COLOR_YELLOW = 3'd2,
    COLOR_GREEN  = 3'd3,
    COLOR_BLUE   = 3'd4,
    COLOR_INDIGO = 3'd5,
    COLOR_PURPLE = 3'd6,
    COLOR_OFF    = 3'd7
  } color_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } fade_state_e;

  localparam rgb_t RGB_OFF = '{r: 8'd0, g: 8'd0, b: 8'd0};

  function automatic rgb_t palette(input color_e code);
    rgb_t c;
    c = RGB_OFF;
    case (code)
      COLOR_RED:    c = '{r: 8'd255, g: 8'd0,   b: 8'd0};
      COLOR_ORANGE: c = '{r: 8'd255, g: 8'd128, b: 8'd0};
      COLOR_YELLOW: c = '{r: 8'd255, g: 8'd255, b: 8'd0};
      COLOR_GREEN:  c = '{r: 8'd0,   g: 8'd255, b: 8'd0};
      COLOR_BLUE:   c = '{r: 8'd0,   g: 8'd0,   b: 8'd255};
      COLOR_INDIGO: c = '{r: 8'd75,  g: 8'd0,   b: 8'd130};
      COLOR_PURPLE: c = '{r: 8'd143, g: 8'd0,   b: 8'd255};
      default:      c = RGB_OFF;
    endcase
    return c;
  endfunction

  // Full scale (8'hFF) passes the level through so a lit channel reaches 255.
  function automatic logic [7:0] scale_duty(input logic [7:0] level,
                                            input logic [7:0] bright);
    logic [15:0] prod;
    prod = 16'(level) * 16'(bright);
    return (bright == 8'hFF) ? level : prod[15:8];
  endfunction

endpackage

// File: rtl/rgb_ramp_channel.sv
// One colour channel level: moves toward its target by at most STEP per
// enabled cycle, landing exactly on the target without overshoot.
module rgb_ramp_channel #(
  parameter int STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic [7:0] target,
  output logic [7:0] level,
  output logic       at_target
);

  localparam logic [8:0] STEP9 = 9'(STEP);

  logic [8:0] lvl9;
  logic [8:0] tgt9;
  logic [8:0] gap;
  logic [7:0] level_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    lvl9    = {1'b0, level};
    tgt9    = {1'b0, target};
    gap     = '0;
    level_d = level;
    if (level < target) begin
      gap     = tgt9 - lvl9;
      level_d = (gap <= STEP9) ? target : 8'(lvl9 + STEP9);
    end else if (level > target) begin
      gap     = lvl9 - tgt9;
      level_d = (gap <= STEP9) ? target : 8'(lvl9 - STEP9);
    end
  end

  assign at_target = (level == target);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          level <= '0;
    else if (step_en) level <= level_d;
  end

endmodule

// File: rtl/rgb_fade_ctrl.sv
// Colour-code to PWM duty converter: fades three channel levels toward the
// palette target once per prescaler tick, then applies global brightness.
module rgb_fade_ctrl
  import rgb_pkg::*;
#(
  parameter int PRESCALE = 256,
  parameter int STEP     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] color_in,
  input  logic       color_valid,
  input  logic [7:0] brightness,
  output logic [7:0] R_duty,
  output logic [7:0] G_duty,
  output logic [7:0] B_duty,
  output logic       busy,
  output logic       done
);

  localparam int                CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] presc_q;
  logic             tick;
  rgb_t             tgt_q;
  fade_state_e      state_q, state_d;
  logic             done_d;
  logic             step_en;
  logic [7:0]       lvl_r, lvl_g, lvl_b;
  logic             at_r, at_g, at_b;

  // Free-running fade timebase; requests never realign it.
  assign tick = (presc_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_q <= '0;
    else     presc_q <= tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              tgt_q <= RGB_OFF;
    else if (color_valid) tgt_q <= palette(color_e'(color_in));
  end

  // A request on a tick still steps toward the old target (tgt_q loads on the
  // same edge) and suppresses completion for that tick.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (color_valid) state_d = ST_FADE;
      ST_FADE: begin
        if (color_valid) begin
          state_d = ST_FADE;
        end else if (tick && at_r && at_g && at_b) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign step_en = (state_q == ST_FADE) && tick;

  rgb_ramp_channel #(.STEP(STEP)) u_ramp_r (
    .clk(clk), .rst(rst), .step_en(step_en), .target(tgt_q.r),
    .level(lvl_r), .at_target(at_r)
  );

  rgb_ramp_channel #(.STEP(STEP)) u_ramp_g (
    .clk(clk), .rst(rst), .step_en(step_en), .target(tgt_q.g),
    .level(lvl_g), .at_target(at_g)
  );

  rgb_ramp_channel #(.STEP(STEP)) u_ramp_b (
    .clk(clk), .rst(rst), .step_en(step_en), .target(tgt_q.b),
    .level(lvl_b), .at_target(at_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == ST_FADE);
      done    <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      R_duty <= '0;
      G_duty <= '0;
      B_duty <= '0;
    end else begin
      R_duty <= scale_duty(lvl_r, brightness);
      G_duty <= scale_duty(lvl_g, brightness);
      B_duty <= scale_duty(lvl_b, brightness);
    end
  end

endmodule
